apb_master_bridge: RTL

Upstream driver for the APB slave memory. Accepts single read/write commands on a valid/ready request port. Runs each command as one APB transfer: SETUP phase, then ACCESS phase with wait states. Returns read data, slave error and timeout status on a valid/ready response port. Only one transfer is outstanding at a time.

---
 rtl/apb_master_bridge.sv | 112 +++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB master driven by a
// valid/ready command port, answering on a valid/ready response port.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    state;
    logic [1:0]    next;
    logic [CW-1:0] wait_cnt;
    logic          cmd_ready_q;
    logic          accept;
    logic          expire;

    assign accept    = (state == IDLE) && cmd_valid && cmd_ready_q;
    assign expire    = (state == ACCESS) && !PREADY && (TIMEOUT != 0)
                       && (wait_cnt == LAST);
    assign cmd_ready = cmd_ready_q;
    assign PSELx     = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    // Next-state decode of the transfer sequence.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (accept) next = SETUP;
            SETUP:   next = ACCESS;
            ACCESS:  if (PREADY || expire) next = RESP;
            RESP:    if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // State register; cmd_ready is registered so it stays low through reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
        end else begin
            state       <= next;
            cmd_ready_q <= (next == IDLE);
        end
    end

    // Command capture, wait counting and response capture.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_err     <= PSLVERR;
                    rsp_timeout <= 1'b0;
                    rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                end else if (expire) begin
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    rsp_rdata   <= '0;
                end else if (TIMEOUT != 0) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule
